writeback_demux: RTL and testbench

- Write-side counterpart of the B-operand source mux in the CPU datapath.
- Takes the ALU result and a 2-bit destination select, then writes it to one of four destinations:
  - the B register,
  - two reserved destination strobes,
  - the LED/output port, which uses a valid/ack handshake to a slow display consumer.
- Destination encoding is identical to the operand mux select encoding, so one control-word field can drive both.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/output_port_handshake.sv | 54 +++++
 rtl/writeback_demux.sv | 85 ++++++++
 tb/tb_writeback_demux.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU datapath types: destination/operand select encoding and
// writeback FSM states.
package cpu_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int WB_COUNT_W = 8;

  // Same encoding drives the B-operand source mux select.
  typedef enum logic [1:0] {
    DEST_BREG = 2'b00,
    DEST_RES1 = 2'b01,
    DEST_RES2 = 2'b10,
    DEST_OUT  = 2'b11
  } dest_sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } wb_state_t;

endpackage

// File: rtl/output_port_handshake.sv
// Output-port side of the writeback demux: latches data for the display
// consumer and holds it (blocking further writes) until acknowledged.
import cpu_pkg::*;

module output_port_handshake #(
  parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] loadData,
  input  logic                  OutputAck,
  output logic                  Ready,
  output logic [DATA_WIDTH-1:0] OutputData,
  output logic                  OutputValid
);

  wb_state_t state;
  wb_state_t stateNext;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (load) stateNext = HOLD;
      HOLD:    if (OutputAck) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Ready comes straight from the state register so the accept path has
  // no combinational dependence on OutputAck.
  assign Ready = (state == IDLE);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      OutputData  <= '0;
      OutputValid <= 1'b0;
    end else if (state == IDLE && load) begin
      OutputData  <= loadData;
      OutputValid <= 1'b1;
    end else if (state == HOLD && OutputAck) begin
      OutputValid <= 1'b0;
    end
  end

endmodule

// File: rtl/writeback_demux.sv
// Writeback demux: routes the ALU result to the B register, reserved strobes
// or the handshaked output port. Optional accept counter: WRITEBACK_COUNT_EN.
import cpu_pkg::*;

module writeback_demux #(
  parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  WriteValid,
  input  logic [1:0]            DestSelect,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  input  logic                  OutputAck,
  output logic                  Ready,
  output logic [DATA_WIDTH-1:0] BRegister,
  output logic [DATA_WIDTH-1:0] ReservedData,
  output logic                  Reserved_1Strobe,
  output logic                  Reserved_2Strobe,
  output logic [DATA_WIDTH-1:0] OutputData,
  output logic                  OutputValid
`ifdef WRITEBACK_COUNT_EN
  ,
  output logic [WB_COUNT_W-1:0] WritebackCount
`endif
);

  dest_sel_t dest;
  logic      accept;

  assign dest   = dest_sel_t'(DestSelect);
  assign accept = WriteValid && Ready;

  output_port_handshake #(
    .DATA_WIDTH(DATA_WIDTH)
  ) uOutPort (
    .Clock      (Clock),
    .Reset      (Reset),
    .load       (accept && dest == DEST_OUT),
    .loadData   (ALUResult),
    .OutputAck  (OutputAck),
    .Ready      (Ready),
    .OutputData (OutputData),
    .OutputValid(OutputValid)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      BRegister    <= '0;
      ReservedData <= '0;
    end else if (accept) begin
      case (dest)
        DEST_BREG:            BRegister    <= ALUResult;
        DEST_RES1, DEST_RES2: ReservedData <= ALUResult;
        default:              ;
      endcase
    end
  end

  // Strobes are recomputed every cycle, so they fall on their own unless
  // another same-destination write is accepted.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Reserved_1Strobe <= 1'b0;
      Reserved_2Strobe <= 1'b0;
    end else begin
      Reserved_1Strobe <= accept && dest == DEST_RES1;
      Reserved_2Strobe <= accept && dest == DEST_RES2;
    end
  end

`ifdef WRITEBACK_COUNT_EN
  function automatic logic [WB_COUNT_W-1:0] satInc(input logic [WB_COUNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      WritebackCount <= '0;
    end else if (accept) begin
      WritebackCount <= satInc(WritebackCount);
    end
  end
`endif

endmodule

// File: tb/tb_writeback_demux.sv
// Bench for writeback_demux: transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_writeback_demux;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       WriteValid = 1'b0;
  logic [1:0] DestSelect = 2'b00;
  logic [7:0] ALUResult = 8'd0;
  logic       OutputAck = 1'b0;
  logic       Ready;
  logic [7:0] BRegister, ReservedData, OutputData;
  logic       Reserved_1Strobe, Reserved_2Strobe, OutputValid;
`ifdef WRITEBACK_COUNT_EN
  logic [7:0] WritebackCount;
`endif

  writeback_demux #(.DATA_WIDTH(8)) dut (
    .Clock           (Clock),
    .Reset           (Reset),
    .WriteValid      (WriteValid),
    .DestSelect      (DestSelect),
    .ALUResult       (ALUResult),
    .OutputAck       (OutputAck),
    .Ready           (Ready),
    .BRegister       (BRegister),
    .ReservedData    (ReservedData),
    .Reserved_1Strobe(Reserved_1Strobe),
    .Reserved_2Strobe(Reserved_2Strobe),
    .OutputData      (OutputData),
    .OutputValid     (OutputValid)
`ifdef WRITEBACK_COUNT_EN
    ,
    .WritebackCount  (WritebackCount)
`endif
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a pending output message either exists or not; writes land only
  // when nothing is pending.
  int  mB, mRes, mOut, mCount;
  bit  mS1, mS2, mPending;

  task automatic modelReset();
    mB = 0; mRes = 0; mOut = 0; mCount = 0;
    mS1 = 0; mS2 = 0; mPending = 0;
  endtask

  task automatic modelStep();
    mS1 = 0;
    mS2 = 0;
    if (mPending) begin
      if (OutputAck) mPending = 0;
    end else if (WriteValid) begin
      case (DestSelect)
        2'd0: mB = ALUResult;
        2'd1: begin mRes = ALUResult; mS1 = 1; end
        2'd2: begin mRes = ALUResult; mS2 = 1; end
        default: begin mOut = ALUResult; mPending = 1; end
      endcase
      if (mCount < 255) mCount++;
    end
  endtask

  task automatic compareAll();
    check("m_ready", Ready, !mPending);
    check("m_breg", BRegister, mB);
    check("m_resdata", ReservedData, mRes);
    check("m_strobe1", Reserved_1Strobe, mS1);
    check("m_strobe2", Reserved_2Strobe, mS2);
    check("m_outdata", OutputData, mOut);
    check("m_outvalid", OutputValid, mPending);
`ifdef WRITEBACK_COUNT_EN
    check("m_count", WritebackCount, mCount);
`endif
  endtask

  always @(posedge Clock or posedge Reset) begin
    if (Reset) modelReset();
    else modelStep();
    #1;
    compareAll();
  end

  task automatic cycle(input bit wv, input int sel, input int data, input bit ack);
    WriteValid = wv;
    DestSelect = sel[1:0];
    ALUResult  = data[7:0];
    OutputAck  = ack;
    @(negedge Clock);
  endtask

  initial begin
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    check("rst_ready", Ready, 1);
    check("rst_breg", BRegister, 0);
    check("rst_valid", OutputValid, 0);

    cycle(1, 0, 1, 0);
    check("breg_first", BRegister, 1);
    check("breg_first_ready", Ready, 1);
    check("breg_first_s1", Reserved_1Strobe, 0);

    cycle(1, 1, 3, 0);
    check("res1_strobe", Reserved_1Strobe, 1);
    check("res1_data", ReservedData, 3);
    cycle(1, 2, 4, 0);
    check("res2_s1_fall", Reserved_1Strobe, 0);
    check("res2_strobe", Reserved_2Strobe, 1);
    check("res2_data", ReservedData, 4);
    cycle(0, 0, 0, 0);
    check("res2_fall", Reserved_2Strobe, 0);

    cycle(1, 3, 2, 0);
    check("out_valid", OutputValid, 1);
    check("out_data", OutputData, 2);
    check("out_ready", Ready, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 9, 0);
      check("hold_valid", OutputValid, 1);
      check("hold_ready", Ready, 0);
      check("hold_breg", BRegister, 1);
    end
    cycle(1, 0, 9, 1);
    check("ack_valid", OutputValid, 0);
    check("ack_ready", Ready, 1);
    check("ack_breg_blocked", BRegister, 1);
    cycle(1, 0, 9, 0);
    check("after_ack_breg", BRegister, 9);

    cycle(0, 0, 0, 1);
    check("idle_ack_valid", OutputValid, 0);
    check("idle_ack_data", OutputData, 2);
    check("idle_ack_ready", Ready, 1);

    cycle(1, 3, 2, 0);
    cycle(0, 0, 0, 0);
    check("pre_rst_valid", OutputValid, 1);
    #2 Reset = 1'b1;
    #1;
    check("async_rst_valid", OutputValid, 0);
    check("async_rst_data", OutputData, 0);
    check("async_rst_breg", BRegister, 0);
    @(negedge Clock);
    Reset = 1'b0;
    check("post_rst_ready", Ready, 1);
    cycle(1, 0, 7, 0);
    check("post_rst_breg", BRegister, 7);

`ifdef WRITEBACK_COUNT_EN
    #2 Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    cycle(1, 3, 5, 0);
    check("cnt_out", WritebackCount, 1);
    for (int i = 0; i < 3; i++) cycle(1, 0, 6, 0);
    check("cnt_blocked", WritebackCount, 1);
    cycle(0, 0, 0, 1);
    check("cnt_ack", WritebackCount, 1);
    for (int i = 0; i < 260; i++) cycle(1, 0, i, 0);
    check("cnt_sat", WritebackCount, 255);
    cycle(1, 1, 8, 0);
    check("cnt_hold", WritebackCount, 255);
`endif

    cycle(0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
